// File: rtl/duck_motion_ctrl.sv
`default_nettype none
// duck_motion_ctrl -- multi-duck movement engine with edge bounce, shot/escape kills and a
// serialized erase/draw handshake toward the VGA drawer.                        Rev 1.0
module duck_motion_ctrl #(
  parameter int N_DUCKS      = 2,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119,
  parameter int STEP         = 1,
  parameter int ESCAPE_TICKS = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic [2*N_DUCKS-1:0] rand_dir,
  input  logic [X_W+Y_W-1:0]   rand_pos,
  input  logic                 shot_valid,
  input  logic [2:0]           shot_idx,
  output logic                 draw_req,
  input  logic                 draw_ack,
  output logic                 draw_erase,
  output logic [2:0]           draw_idx,
  output logic [X_W-1:0]       draw_x,
  output logic [Y_W-1:0]       draw_y,
  output logic [N_DUCKS-1:0]   alive,
  output logic                 hit,
  output logic                 escaped,
  output logic                 tick_miss
);

  localparam int IDX_W = (N_DUCKS > 1) ? $clog2(N_DUCKS) : 1;
  localparam int NSLOT = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_SVC   = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4,
    S_DRAW  = 3'd5
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic             r_spawn;
  logic             r_tick_pend;
  logic [NSLOT-1:0] r_alive;
  logic [NSLOT-1:0] r_erase_pend;
  logic [NSLOT-1:0] r_dx;
  logic [NSLOT-1:0] r_dy;
  logic [X_W-1:0]   r_x   [NSLOT];
  logic [Y_W-1:0]   r_y   [NSLOT];
  logic [7:0]       r_age [NSLOT];

  logic [IDX_W-1:0] w_i;
  logic [IDX_W-1:0] w_shot_slot;
  logic             w_shot_hit;
  logic             w_shot_on_cur;
  logic             w_last;
  state_t           w_adv_state;
  logic [2:0]       w_adv_idx;
  logic [X_W-1:0]   w_seed_x;
  logic [Y_W-1:0]   w_seed_y;
  logic [X_W-1:0]   w_spawn_x;
  logic [Y_W-1:0]   w_spawn_y;
  logic [X_W-1:0]   w_cur_x;
  logic [Y_W-1:0]   w_cur_y;
  logic [X_W:0]     w_x_plus;
  logic [Y_W:0]     w_y_plus;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic             w_ndx;
  logic             w_ndy;
  logic [7:0]       w_age_nx;
  logic             w_esc;

  assign w_i           = r_idx[IDX_W-1:0];
  assign w_shot_slot   = shot_idx[IDX_W-1:0];
  assign w_shot_hit    = shot_valid && (int'(shot_idx) < N_DUCKS) && r_alive[w_shot_slot];
  assign w_shot_on_cur = w_shot_hit && (shot_idx == r_idx);
  assign w_last        = (r_idx == 3'(N_DUCKS - 1));
  assign w_adv_state   = w_last ? S_IDLE : S_SVC;
  assign w_adv_idx     = w_last ? r_idx : r_idx + 3'd1;

  assign w_seed_x  = rand_pos[X_W-1:0];
  assign w_seed_y  = rand_pos[X_W+Y_W-1:X_W];
  assign w_spawn_x = (int'(w_seed_x) > X_MAX) ? X_W'(X_MAX) : w_seed_x;
  assign w_spawn_y = (int'(w_seed_y) > Y_MAX) ? Y_W'(Y_MAX) : w_seed_y;

  assign w_cur_x  = r_x[w_i];
  assign w_cur_y  = r_y[w_i];
  assign w_x_plus = {1'b0, w_cur_x} + (X_W+1)'(STEP);
  assign w_y_plus = {1'b0, w_cur_y} + (Y_W+1)'(STEP);
  assign w_age_nx = r_age[w_i] + 8'd1;
  assign w_esc    = (w_age_nx == 8'(ESCAPE_TICKS));

  // Bounce clamps to the edge and flips direction; coordinates never wrap.
  always_comb begin
    w_nx  = w_cur_x;
    w_ndx = r_dx[w_i];
    if (r_dx[w_i]) begin
      if (int'(w_x_plus) > X_MAX) begin
        w_nx  = X_W'(X_MAX);
        w_ndx = 1'b0;
      end else begin
        w_nx = w_x_plus[X_W-1:0];
      end
    end else if (int'(w_cur_x) < STEP) begin
      w_nx  = '0;
      w_ndx = 1'b1;
    end else begin
      w_nx = w_cur_x - X_W'(STEP);
    end

    w_ny  = w_cur_y;
    w_ndy = r_dy[w_i];
    if (r_dy[w_i]) begin
      if (int'(w_y_plus) > Y_MAX) begin
        w_ny  = Y_W'(Y_MAX);
        w_ndy = 1'b0;
      end else begin
        w_ny = w_y_plus[Y_W-1:0];
      end
    end else if (int'(w_cur_y) < STEP) begin
      w_ny  = '0;
      w_ndy = 1'b1;
    end else begin
      w_ny = w_cur_y - Y_W'(STEP);
    end
  end

  assign alive = r_alive[N_DUCKS-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_spawn      <= 1'b0;
      r_tick_pend  <= 1'b0;
      r_alive      <= '0;
      r_erase_pend <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        r_x[k]   <= '0;
        r_y[k]   <= '0;
        r_age[k] <= '0;
      end
      draw_req   <= 1'b0;
      draw_erase <= 1'b0;
      draw_idx   <= '0;
      draw_x     <= '0;
      draw_y     <= '0;
      hit        <= 1'b0;
      escaped    <= 1'b0;
      tick_miss  <= 1'b0;
    end else begin
      hit       <= w_shot_hit;
      escaped   <= 1'b0;
      tick_miss <= 1'b0;

      if (r_state == S_IDLE) begin
        if (tick || r_tick_pend) r_tick_pend <= 1'b0;
      end else if (tick) begin
        if (r_tick_pend) tick_miss <= 1'b1;
        else             r_tick_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_spawn <= 1'b0;
          if (tick || r_tick_pend) begin
            r_idx   <= '0;
            r_state <= (r_alive == '0) ? S_SPAWN : S_SVC;
          end
        end
        S_SPAWN: begin
          for (int k = 0; k < N_DUCKS; k++) begin
            r_alive[k] <= 1'b1;
            r_age[k]   <= '0;
            r_x[k]     <= w_spawn_x;
            r_y[k]     <= w_spawn_y;
            r_dx[k]    <= rand_dir[2*k];
            r_dy[k]    <= rand_dir[2*k+1];
          end
          r_erase_pend <= '0;
          r_spawn      <= 1'b1;
          r_state      <= S_SVC;
        end
        S_SVC: begin
          draw_idx <= r_idx;
          draw_x   <= w_cur_x;
          draw_y   <= w_cur_y;
          if (r_alive[w_i]) begin
            draw_req   <= 1'b1;
            draw_erase <= !r_spawn;
            r_state    <= r_spawn ? S_DRAW : S_ERASE;
          end else if (r_erase_pend[w_i]) begin
            r_erase_pend[w_i] <= 1'b0;
            draw_req          <= 1'b1;
            draw_erase        <= 1'b1;
            r_state           <= S_ERASE;
          end else begin
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
          end
        end
        S_ERASE: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            if (r_alive[w_i] && !w_shot_on_cur) begin
              r_state <= S_MOVE;
            end else begin
              r_state <= w_adv_state;
              r_idx   <= w_adv_idx;
            end
          end
        end
        S_MOVE: begin
          // A shot landing now outranks the escape; the sprite is already erased.
          if (w_shot_on_cur || !r_alive[w_i]) begin
            r_state <= w_adv_state;
            r_idx   <= w_adv_idx;
          end else if (w_esc) begin
            r_age[w_i]        <= w_age_nx;
            r_alive[w_i]      <= 1'b0;
            r_erase_pend[w_i] <= 1'b1;
            escaped           <= 1'b1;
            r_state           <= w_adv_state;
            r_idx             <= w_adv_idx;
          end else begin
            r_age[w_i] <= w_age_nx;
            r_x[w_i]   <= w_nx;
            r_y[w_i]   <= w_ny;
            r_dx[w_i]  <= w_ndx;
            r_dy[w_i]  <= w_ndy;
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
            draw_idx   <= r_idx;
            draw_x     <= w_nx;
            draw_y     <= w_ny;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            r_state  <= w_adv_state;
            r_idx    <= w_adv_idx;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_shot_hit) begin
        r_alive[w_shot_slot]      <= 1'b0;
        r_erase_pend[w_shot_slot] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_duck_motion_ctrl.sv
`default_nettype none
// tb_duck_motion_ctrl -- directed scoreboard bench for duck_motion_ctrl (2 ducks, escape after 4 ticks).
module tb_duck_motion_ctrl;

  localparam int N    = 2;
  localparam int XMAX = 159;
  localparam int YMAX = 119;
  localparam int STEP = 1;
  localparam int ESC  = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        tick       = 1'b0;
  logic [3:0]  rand_dir   = '0;
  logic [14:0] rand_pos   = '0;
  logic        shot_valid = 1'b0;
  logic [2:0]  shot_idx   = '0;
  logic        draw_ack   = 1'b0;
  logic        draw_req, draw_erase, hit, escaped, tick_miss;
  logic [2:0]  draw_idx;
  logic [7:0]  draw_x;
  logic [6:0]  draw_y;
  logic [1:0]  alive;

  always #5 clk = ~clk;

  duck_motion_ctrl #(
    .N_DUCKS(N), .X_W(8), .Y_W(7), .X_MAX(XMAX), .Y_MAX(YMAX),
    .STEP(STEP), .ESCAPE_TICKS(ESC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .rand_dir(rand_dir), .rand_pos(rand_pos),
    .shot_valid(shot_valid), .shot_idx(shot_idx), .draw_req(draw_req), .draw_ack(draw_ack),
    .draw_erase(draw_erase), .draw_idx(draw_idx), .draw_x(draw_x), .draw_y(draw_y),
    .alive(alive), .hit(hit), .escaped(escaped), .tick_miss(tick_miss)
  );

  int n_chk = 0;
  int n_fail = 0;
  int hit_cnt = 0;
  int esc_cnt = 0;
  int miss_cnt = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [18:0] expq [$];

  // Reference model of the duck field
  int mx [N];
  int my [N];
  int mage [N];
  bit mdx [N];
  bit mdy [N];
  bit mal [N];
  bit mpd [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit e, input int i, input int x, input int y);
    expq.push_back({e, 3'(i), 8'(x), 7'(y)});
  endtask

  task automatic mstep(inout int p, inout bit d, input int pmax);
    if (d) begin
      if (p + STEP > pmax) begin p = pmax; d = 1'b0; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 1'b1; end
      else p = p - STEP;
    end
  endtask

  task automatic model_spawn();
    int sx = int'(rand_pos[7:0]);
    int sy = int'(rand_pos[14:8]);
    if (sx > XMAX) sx = XMAX;
    if (sy > YMAX) sy = YMAX;
    for (int i = 0; i < N; i++) begin
      mal[i] = 1'b1; mpd[i] = 1'b0; mage[i] = 0;
      mx[i] = sx; my[i] = sy;
      mdx[i] = rand_dir[2*i]; mdy[i] = rand_dir[2*i+1];
      push(1'b0, i, mx[i], my[i]);
    end
  endtask

  // kill_at_move: duck shot during its own move cycle (no draw, no escape)
  task automatic model_sweep(input int kill_at_move, output int n_esc);
    n_esc = 0;
    for (int i = 0; i < N; i++) begin
      if (mal[i]) begin
        push(1'b1, i, mx[i], my[i]);
        if (i == kill_at_move) begin
          mal[i] = 1'b0; mpd[i] = 1'b1;
        end else begin
          mage[i]++;
          if (mage[i] == ESC) begin
            mal[i] = 1'b0; mpd[i] = 1'b1; n_esc++;
          end else begin
            mstep(mx[i], mdx[i], XMAX);
            mstep(my[i], mdy[i], YMAX);
            push(1'b0, i, mx[i], my[i]);
          end
        end
      end else if (mpd[i]) begin
        push(1'b1, i, mx[i], my[i]);
        mpd[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (hit) hit_cnt++;
    if (escaped) esc_cnt++;
    if (tick_miss) miss_cnt++;
  end

  // Drawer: scoreboard compare on first sight of a request, one-cycle ack after ack_delay
  always @(negedge clk) begin
    if (draw_ack) begin
      draw_ack = 1'b0;
    end else if (draw_req) begin
      if (wait_cnt == 0) begin
        check("draw_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0)
          check("draw_txn", {13'd0, draw_erase, draw_idx, draw_x, draw_y}, {13'd0, expq.pop_front()});
      end
      if (wait_cnt >= ack_delay) begin
        draw_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((expq.size() != 0 || draw_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("sweep_budget", 32'(n < 500), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_tick();
    int e0 = esc_cnt;
    int ee = 0;
    if (!mal[0] && !mal[1]) model_spawn();
    else model_sweep(-1, ee);
    pulse_tick();
    wait_done();
    check("escaped_count", 32'(esc_cnt - e0), 32'(ee));
    check("alive", 32'(alive), {30'd0, mal[1], mal[0]});
  endtask

  task automatic shoot(input logic [2:0] idx);
    int h0 = hit_cnt;
    int eh = 0;
    if (int'(idx) < N) begin
      if (mal[idx]) begin
        eh = 1; mal[idx] = 1'b0; mpd[idx] = 1'b1;
      end
    end
    @(negedge clk); shot_idx = idx; shot_valid = 1'b1;
    @(negedge clk); shot_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("hit_count", 32'(hit_cnt - h0), 32'(eh));
    check("alive_after_shot", 32'(alive), {30'd0, mal[1], mal[0]});
  endtask

  initial begin
    int n, m0, h0, e0, ee;
    for (int i = 0; i < N; i++) begin
      mal[i] = 1'b0; mpd[i] = 1'b0; mx[i] = 0; my[i] = 0; mage[i] = 0; mdx[i] = 1'b0; mdy[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("rst_draw_req", 32'(draw_req), 32'd0);
    check("rst_draw_erase", 32'(draw_erase), 32'd0);
    check("rst_draw_idx", 32'(draw_idx), 32'd0);
    check("rst_draw_x", 32'(draw_x), 32'd0);
    check("rst_draw_y", 32'(draw_y), 32'd0);
    check("rst_alive", 32'(alive), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_escaped", 32'(escaped), 32'd0);
    check("rst_tick_miss", 32'(tick_miss), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Wave A: spawn at (10,20) moving right/up, shots, duck0 escapes on its 4th move
    rand_pos = {7'd20, 8'd10};
    rand_dir = 4'b0101;
    do_tick();
    do_tick();
    shoot(3'd5);
    shoot(3'd1);
    do_tick();
    shoot(3'd1);
    do_tick();
    do_tick();

    // Wave B: clamped spawn at the bottom-right corner, bounce, stalled drawer, double escape
    rand_pos = {7'd127, 8'd255};
    rand_dir = 4'b0011;
    do_tick();
    do_tick();
    m0 = miss_cnt;
    ack_delay = 1000;
    model_sweep(-1, ee);
    pulse_tick();
    repeat (10) @(negedge clk);
    pulse_tick();
    repeat (10) @(negedge clk);
    pulse_tick();
    repeat (28) @(negedge clk);
    check("hold_req", 32'(draw_req), 32'd1);
    check("hold_erase", 32'(draw_erase), 32'd1);
    check("hold_idx", 32'(draw_idx), 32'd0);
    check("hold_x", 32'(draw_x), 32'd159);
    check("hold_y", 32'(draw_y), 32'd119);
    check("tick_miss_count", 32'(miss_cnt - m0), 32'd1);
    model_sweep(-1, ee);
    ack_delay = 0;
    wait_done();
    check("alive_after_pending", 32'(alive), {30'd0, mal[1], mal[0]});
    do_tick();
    check("both_escaped", 32'(alive), 32'd0);

    // Wave C: respawn, then shot on duck0 in the same cycle its escape would fire
    rand_pos = {7'd20, 8'd10};
    rand_dir = 4'b0101;
    do_tick();
    do_tick();
    do_tick();
    do_tick();
    shoot(3'd1);
    h0 = hit_cnt;
    e0 = esc_cnt;
    model_sweep(0, ee);
    pulse_tick();
    n = 0;
    while (!(draw_req && draw_erase && draw_idx == 3'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("found_erase0", 32'(n < 100), 32'd1);
    @(negedge clk); shot_idx = 3'd0; shot_valid = 1'b1;
    @(negedge clk); shot_valid = 1'b0;
    wait_done();
    check("same_cycle_hit", 32'(hit_cnt - h0), 32'd1);
    check("same_cycle_escaped", 32'(esc_cnt - e0), 32'd0);
    check("alive_after_same_cycle", 32'(alive), 32'd0);
    do_tick();

    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
